// File: rtl/exe_stage.sv
// exe_stage: LoongArch32 execute stage.
// ALU, 33x33 multiply, radix-2 restoring divider, data-SRAM request.
module exe_stage #(
  parameter int ID_TO_EXE_WD  = 157,
  parameter int EXE_TO_MEM_WD = 76,
  parameter int EXE_TO_ID_WD  = 40
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     id_to_exe_valid,
  input  logic [ID_TO_EXE_WD-1:0]  id_to_exe_bus,
  output logic                     exe_allowin,
  input  logic                     mem_allowin,
  output logic                     exe_to_mem_valid,
  output logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
  output logic [EXE_TO_ID_WD-1:0]  exe_to_id_bus,
  output logic                     data_sram_en,
  output logic [3:0]               data_sram_we,
  output logic [31:0]              data_sram_addr,
  output logic [31:0]              data_sram_wdata
);

  typedef struct packed {
    logic [11:0] alu_op;
    logic        rfm;
    logic        regw;
    logic        memw;
    logic [4:0]  waddr;
    logic [31:0] rkd;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        div_sgn;
    logic        mul_sgn;
    logic        div;
    logic [2:0]  md_sel;
    logic [1:0]  mem_size;
    logic        ld_sgn;
    logic [31:0] pc;
  } id_exe_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  id_exe_t     data_q;
  logic        valid_q;
  logic        ready_go;

  logic [1:0]  div_state_q, div_state_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [31:0] div_r_q, div_r_d;
  logic [31:0] div_qt_q, div_qt_d;
  logic [31:0] div_b_q, div_b_d;

  logic [31:0] alu_res;
  logic [31:0] result;

  assign ready_go = ~data_q.div | (div_state_q == S_DONE);
  assign exe_allowin = ~valid_q | ready_go & mem_allowin;
  assign exe_to_mem_valid = valid_q & ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (exe_allowin)
        valid_q <= id_to_exe_valid;
      if (exe_allowin & id_to_exe_valid)
        data_q <= id_exe_t'(id_to_exe_bus);
    end
  end

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      data_q.alu_op[0]:  alu_res = data_q.src1 + data_q.src2;
      data_q.alu_op[1]:  alu_res = data_q.src1 - data_q.src2;
      data_q.alu_op[2]:
        alu_res = {31'd0, $signed(data_q.src1) < $signed(data_q.src2)};
      data_q.alu_op[3]:  alu_res = {31'd0, data_q.src1 < data_q.src2};
      data_q.alu_op[4]:  alu_res = data_q.src1 & data_q.src2;
      data_q.alu_op[5]:  alu_res = ~(data_q.src1 | data_q.src2);
      data_q.alu_op[6]:  alu_res = data_q.src1 | data_q.src2;
      data_q.alu_op[7]:  alu_res = data_q.src1 ^ data_q.src2;
      data_q.alu_op[8]:  alu_res = data_q.src1 << data_q.src2[4:0];
      data_q.alu_op[9]:  alu_res = data_q.src1 >> data_q.src2[4:0];
      data_q.alu_op[10]:
        alu_res = $signed(data_q.src1) >>> data_q.src2[4:0];
      data_q.alu_op[11]: alu_res = data_q.src2;
      default:           alu_res = '0;
    endcase
  end

  // 64-bit sign/zero extension yields the exact 33x33 product low word pair
  logic [63:0] mul_a, mul_b, mul_p;
  assign mul_a = {{32{data_q.mul_sgn & data_q.src1[31]}}, data_q.src1};
  assign mul_b = {{32{data_q.mul_sgn & data_q.src2[31]}}, data_q.src2};
  assign mul_p = mul_a * mul_b;

  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_abs, dvs_abs;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [31:0] quot, rem;

  assign dvd_neg = data_q.div_sgn & data_q.src1[31];
  assign dvs_neg = data_q.div_sgn & data_q.src2[31];
  assign dvd_abs = dvd_neg ? -data_q.src1 : data_q.src1;
  assign dvs_abs = dvs_neg ? -data_q.src2 : data_q.src2;
  assign rem_sh  = {div_r_q, div_qt_q[31]};
  assign diff    = {1'b0, rem_sh} - {2'b00, div_b_q};
  assign quot    = (dvd_neg ^ dvs_neg) ? -div_qt_q : div_qt_q;
  assign rem     = dvd_neg ? -div_r_q : div_r_q;

  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_r_d     = div_r_q;
    div_qt_d    = div_qt_q;
    div_b_d     = div_b_q;
    unique case (div_state_q)
      S_IDLE: begin
        if (valid_q & data_q.div) begin
          div_state_d = S_BUSY;
          div_cnt_d   = 5'd0;
          div_r_d     = '0;
          div_qt_d    = dvd_abs;
          div_b_d     = dvs_abs;
        end
      end
      S_BUSY: begin
        div_qt_d  = {div_qt_q[30:0], ~diff[33]};
        div_r_d   = diff[33] ? rem_sh[31:0] : diff[31:0];
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31)
          div_state_d = S_DONE;
      end
      S_DONE: begin
        if (exe_to_mem_valid & mem_allowin)
          div_state_d = S_IDLE;
      end
      default: div_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state_q <= S_IDLE;
      div_cnt_q   <= '0;
      div_r_q     <= '0;
      div_qt_q    <= '0;
      div_b_q     <= '0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_r_q     <= div_r_d;
      div_qt_q    <= div_qt_d;
      div_b_q     <= div_b_d;
    end
  end

  always_comb begin
    result = '0;
    unique case (data_q.md_sel)
      3'd0:    result = alu_res;
      3'd1:    result = mul_p[31:0];
      3'd2:    result = mul_p[63:32];
      3'd3:    result = quot;
      3'd4:    result = rem;
      default: result = '0;
    endcase
  end

  logic [3:0] st_we;

  assign data_sram_en = valid_q & ready_go & mem_allowin
                      & (data_q.rfm | data_q.memw);
  assign data_sram_addr = alu_res;

  always_comb begin
    st_we = 4'b0000;
    data_sram_wdata = data_q.rkd;
    unique case (data_q.mem_size)
      2'b01: begin
        st_we = 4'b0001 << alu_res[1:0];
        data_sram_wdata = {4{data_q.rkd[7:0]}};
      end
      2'b10: begin
        st_we = alu_res[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{data_q.rkd[15:0]}};
      end
      2'b11:   st_we = 4'b1111;
      default: st_we = 4'b0000;
    endcase
  end

  assign data_sram_we = (data_q.memw & data_sram_en) ? st_we : 4'b0000;

  assign exe_to_mem_bus = {data_q.rfm, data_q.regw, data_q.waddr,
                           data_q.mem_size, data_q.ld_sgn,
                           alu_res[1:0], result, data_q.pc};
  assign exe_to_id_bus = {valid_q, data_q.rfm, data_q.regw,
                          data_q.waddr, result};

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed literals plus random traffic checked
// every cycle against a behavioural model of the execute stage.
module tb_exe_stage;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        rfm;
    logic        regw;
    logic        memw;
    logic [4:0]  waddr;
    logic [31:0] rkd;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        div_sgn;
    logic        mul_sgn;
    logic        div;
    logic [2:0]  md_sel;
    logic [1:0]  mem_size;
    logic        ld_sgn;
    logic [31:0] pc;
  } ins_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic id_valid = 1'b0;
  logic mem_allowin = 1'b1;
  ins_t bus_s = '0;

  logic        exe_allowin, exe_to_mem_valid, data_sram_en;
  logic [75:0] to_mem;
  logic [39:0] to_id;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk),
    .resetn(resetn),
    .id_to_exe_valid(id_valid),
    .id_to_exe_bus(bus_s),
    .exe_allowin(exe_allowin),
    .mem_allowin(mem_allowin),
    .exe_to_mem_valid(exe_to_mem_valid),
    .exe_to_mem_bus(to_mem),
    .exe_to_id_bus(to_id),
    .data_sram_en(data_sram_en),
    .data_sram_we(sram_we),
    .data_sram_addr(sram_addr),
    .data_sram_wdata(sram_wdata)
  );

  task automatic chk(input string nm, input logic [75:0] act,
                     input logic [75:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] f_alu(input ins_t i);
    case (i.alu_op)
      12'h001: return i.src1 + i.src2;
      12'h002: return i.src1 - i.src2;
      12'h004: return (int'(i.src1) < int'(i.src2)) ? 32'd1 : 32'd0;
      12'h008: return (i.src1 < i.src2) ? 32'd1 : 32'd0;
      12'h010: return i.src1 & i.src2;
      12'h020: return ~(i.src1 | i.src2);
      12'h040: return i.src1 | i.src2;
      12'h080: return i.src1 ^ i.src2;
      12'h100: return i.src1 << i.src2[4:0];
      12'h200: return i.src1 >> i.src2[4:0];
      12'h400: return 32'(int'(i.src1) >>> i.src2[4:0]);
      12'h800: return i.src2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_res(input ins_t i);
    logic [63:0] p;
    logic [31:0] q, r;
    int a, b;
    if (i.mul_sgn)
      p = 64'(longint'(int'(i.src1)) * longint'(int'(i.src2)));
    else
      p = {32'd0, i.src1} * {32'd0, i.src2};
    a = int'(i.src1);
    b = int'(i.src2);
    if (!i.div_sgn) begin
      q = (i.src2 == 0) ? 32'hFFFFFFFF : i.src1 / i.src2;
      r = (i.src2 == 0) ? i.src1 : i.src1 % i.src2;
    end else if (b == 0) begin
      q = (a < 0) ? 32'd1 : 32'hFFFFFFFF;
      r = i.src1;
    end else if (i.src1 == 32'h80000000 && b == -1) begin
      q = 32'h80000000;
      r = 32'd0;
    end else begin
      q = 32'(a / b);
      r = 32'(a % b);
    end
    case (i.md_sel)
      3'd0: return f_alu(i);
      3'd1: return p[31:0];
      3'd2: return p[63:32];
      3'd3: return q;
      3'd4: return r;
      default: return 32'd0;
    endcase
  endfunction

  // model: one slot plus the number of edges since the instruction entered
  logic m_valid = 1'b0;
  ins_t m_ins = '0;
  int   m_age = 0;

  function automatic logic m_rdy();
    return !m_ins.div || m_age >= 33;
  endfunction

  function automatic logic m_allow();
    return !m_valid || (m_rdy() && mem_allowin);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_ins   <= '0;
      m_age   <= 0;
    end else begin
      if (m_allow())
        m_valid <= id_valid;
      if (m_allow() && id_valid) begin
        m_ins <= bus_s;
        m_age <= 0;
      end else if (m_age < 1000) begin
        m_age <= m_age + 1;
      end
    end
  end

  logic        e_rdy, e_en;
  logic [31:0] e_res, e_alu, e_wd;
  logic [3:0]  e_we;
  int          e_off, e_nb;

  always @(negedge clk) begin
    e_rdy = m_rdy();
    e_res = f_res(m_ins);
    e_alu = f_alu(m_ins);
    e_en  = m_valid & e_rdy & mem_allowin & (m_ins.rfm | m_ins.memw);
    e_nb  = (m_ins.mem_size == 2'd3) ? 4 : int'(m_ins.mem_size);
    e_off = (e_nb == 0) ? 0 : (int'(e_alu[1:0]) / e_nb) * e_nb;
    e_we  = '0;
    e_wd  = m_ins.rkd;
    for (int b = 0; b < 4; b++) begin
      if (b >= e_off && b < e_off + e_nb && m_ins.memw && e_en)
        e_we[b] = 1'b1;
      if (e_nb != 0)
        e_wd[8*b +: 8] = m_ins.rkd[8*(b % e_nb) +: 8];
    end
    chk("allowin", exe_allowin, m_allow());
    chk("to_mem_valid", exe_to_mem_valid, m_valid & e_rdy);
    chk("sram_en", data_sram_en, e_en);
    chk("sram_we", sram_we, e_we);
    chk("sram_addr", sram_addr, e_alu);
    chk("sram_wdata", sram_wdata, e_wd);
    chk("mem_bus_hdr", to_mem[75:64],
        {m_ins.rfm, m_ins.regw, m_ins.waddr, m_ins.mem_size,
         m_ins.ld_sgn, e_alu[1:0]});
    chk("mem_bus_pc", to_mem[31:0], m_ins.pc);
    chk("id_bus_hdr", to_id[39:32],
        {m_valid, m_ins.rfm, m_ins.regw, m_ins.waddr});
    if (!m_ins.div || (m_valid && e_rdy)) begin
      chk("mem_bus_res", to_mem[63:32], e_res);
      chk("id_bus_res", to_id[31:0], e_res);
    end
  end

  function automatic ins_t mk(input logic [11:0] op,
                              input logic [2:0] md, input logic dv,
                              input logic sg, input logic [31:0] a,
                              input logic [31:0] b,
                              input logic [4:0] wa);
    ins_t i = '0;
    i.alu_op = op;
    i.md_sel = md;
    i.div = dv;
    i.div_sgn = sg;
    i.mul_sgn = sg;
    i.src1 = a;
    i.src2 = b;
    i.regw = 1'b1;
    i.waddr = wa;
    i.pc = 32'h1C00_0000 + 32'(wa) * 4;
    return i;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 16;
      4: return -($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i = '0;
    int k = $urandom_range(0, 9);
    int s = $urandom_range(0, 12);
    i.alu_op = (s == 12) ? 12'd0 : 12'd1 << s;
    i.src1 = rnd_op();
    i.src2 = rnd_op();
    i.rkd = $urandom;
    i.pc = $urandom;
    i.waddr = 5'($urandom);
    i.regw = 1'($urandom);
    i.ld_sgn = 1'($urandom);
    i.mem_size = 2'($urandom);
    if (k == 6) begin
      i.md_sel = 3'($urandom_range(1, 2));
      i.mul_sgn = 1'($urandom);
    end else if (k == 7) begin
      i.div = 1'b1;
      i.md_sel = 3'($urandom_range(3, 4));
      i.div_sgn = 1'($urandom);
    end else if (k >= 8) begin
      i.alu_op = 12'h001;
      i.mem_size = 2'($urandom_range(1, 3));
      if ($urandom % 2) i.memw = 1'b1;
      else i.rfm = 1'b1;
    end
    return i;
  endfunction

  task automatic issue(input ins_t i);
    bit ok = 0;
    @(posedge clk); #1;
    id_valid = 1'b1;
    bus_s = i;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = m_allow();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: allowin 0, required 1");
    end
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input logic [31:0] exp,
                          output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exe_to_mem_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: valid 0, required 1", nm);
    end else begin
      chk(nm, to_mem[63:32], exp);
    end
  endtask

  initial begin
    int lat, cnt;
    ins_t i;
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    ins_t i;
    repeat (3) @(negedge clk);
    chk("rst_allowin", exe_allowin, 1'b1);
    chk("rst_to_mem_valid", exe_to_mem_valid, 1'b0);
    chk("rst_sram_en", data_sram_en, 1'b0);
    chk("rst_sram_we", sram_we, 4'b0000);
    resetn = 1'b1;

    chk("model_divq", f_res(mk(12'd0, 3'd3, 1, 1, -7, 2, 1)), 32'hFFFFFFFD);
    chk("model_mulhu",
        f_res(mk(12'd0, 3'd2, 0, 0, '1, '1, 1)), 32'hFFFFFFFE);

    issue(mk(12'h001, 3'd0, 0, 0, 32'd5, 32'hFFFFFFFE, 5'd7));
    wait_out("add_res", 32'd3, lat);
    chk("add_latency", lat, 0);
    chk("add_id_bus", to_id, {1'b1, 1'b0, 1'b1, 5'd7, 32'd3});

    issue(mk(12'd0, 3'd3, 1, 1, -7, 2, 5'd8));
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exe_allowin) break;
      cnt++;
    end
    chk("div_stall_cycles", cnt, 33);
    chk("div_done_valid", exe_to_mem_valid, 1'b1);
    chk("div_quot", to_mem[63:32], 32'hFFFFFFFD);
    id_valid = 1'b1;
    bus_s = mk(12'd0, 3'd4, 1, 1, -7, 2, 5'd9);
    @(posedge clk); #1;
    id_valid = 1'b0;
    @(negedge clk);
    chk("rem_enters", to_id[39:32], {1'b1, 1'b0, 1'b1, 5'd9});
    wait_out("div_rem", 32'hFFFFFFFF, lat);

    issue(mk(12'd0, 3'd3, 1, 0, 32'h1234, 32'd0, 5'd10));
    wait_out("divu0_quot", 32'hFFFFFFFF, lat);
    chk("divu0_latency", lat, 33);
    issue(mk(12'd0, 3'd4, 1, 0, 32'h1234, 32'd0, 5'd11));
    wait_out("divu0_rem", 32'h1234, lat);
    issue(mk(12'd0, 3'd3, 1, 1, 32'h80000000, '1, 5'd12));
    wait_out("ovf_quot", 32'h80000000, lat);
    issue(mk(12'd0, 3'd4, 1, 1, 32'h80000000, '1, 5'd13));
    wait_out("ovf_rem", 32'd0, lat);

    issue(mk(12'd0, 3'd2, 0, 1, '1, '1, 5'd14));
    wait_out("mulh", 32'd0, lat);
    issue(mk(12'd0, 3'd2, 0, 0, '1, '1, 5'd15));
    wait_out("mulhu", 32'hFFFFFFFE, lat);
    issue(mk(12'd0, 3'd1, 0, 1, '1, '1, 5'd16));
    wait_out("mul_lo", 32'd1, lat);

    i = mk(12'h001, 3'd0, 0, 0, 32'h1000, 32'd3, 5'd0);
    i.regw = 1'b0;
    i.memw = 1'b1;
    i.mem_size = 2'b01;
    i.rkd = 32'h000000AB;
    i.pc = 32'h1C00_0100;
    issue(i);
    mem_allowin = 1'b0;
    @(negedge clk);
    chk("stb_hold_en", data_sram_en, 1'b0);
    chk("stb_hold_we", sram_we, 4'b0000);
    chk("stb_hold_allowin", exe_allowin, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stb_held_pc", to_mem[31:0], 32'h1C00_0100);
    @(posedge clk); #1;
    mem_allowin = 1'b1;
    @(negedge clk);
    chk("stb_en", data_sram_en, 1'b1);
    chk("stb_we", sram_we, 4'b1000);
    chk("stb_wdata", sram_wdata, 32'hABABABAB);
    chk("stb_addr", sram_addr, 32'h00001003);

    issue(mk(12'd0, 3'd3, 1, 1, 32'd100, 32'd7, 5'd17));
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstdiv_valid", to_id[39], 1'b0);
    chk("rstdiv_to_mem", exe_to_mem_valid, 1'b0);
    chk("rstdiv_allowin", exe_allowin, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    issue(mk(12'h001, 3'd0, 0, 0, 32'd40, 32'd2, 5'd18));
    wait_out("post_rst_add", 32'd42, lat);
    chk("post_rst_latency", lat, 0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      mem_allowin = ($urandom % 4) != 0;
      id_valid = ($urandom % 3) != 0;
      bus_s = rnd_ins();
    end
    @(posedge clk); #1;
    id_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
